// File: rtl/rio_stream_pkg.sv
// rtl/rio_stream_pkg.sv - shared types and default widths for the output writer
// Purpose: state encoding of the store-and-forward writer and its default
//          parameter values, shared by the interface, RAM wrapper and top.
// Ports:   none (package).
`timescale 1ns/1ps
package rio_stream_pkg;

  localparam int DEFAULT_DATA_WIDTH        = 64;
  localparam int DEFAULT_DATA_LENGTH_WIDTH = 20;
  localparam int DEFAULT_RAM_ADDR_WIDTH    = 10;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } wr_state_e;

endpackage

// File: rtl/output_writer_if.sv
// rtl/output_writer_if.sv - stream-in / user-out signal bundle of the output writer
// Purpose: groups the receive stream, the user-side beat port and the
//          overflow flag into one bundle.
// Modports:
//   slave  - writer view: consumes input_t*, data_ready_in; drives the rest.
//   master - environment view: drives input_t*, data_ready_in.
`timescale 1ns/1ps
interface output_writer_if #(
  parameter int DATA_WIDTH        = rio_stream_pkg::DEFAULT_DATA_WIDTH,
  parameter int DATA_LENGTH_WIDTH = rio_stream_pkg::DEFAULT_DATA_LENGTH_WIDTH
);

  logic [DATA_WIDTH-1:0]        input_tdata;
  logic                         input_tvalid;
  logic [DATA_WIDTH/8-1:0]      input_tkeep;
  logic                         input_tlast;
  logic                         input_tready;

  logic [DATA_WIDTH-1:0]        data_out;
  logic                         data_valid_out;
  logic [DATA_WIDTH/8-1:0]      data_keep_out;
  logic [DATA_LENGTH_WIDTH-1:0] data_len_out;
  logic                         data_last_out;
  logic                         data_ready_in;

  logic                         overflow_o;

  modport slave (
    input  input_tdata, input_tvalid, input_tkeep, input_tlast, data_ready_in,
    output input_tready, data_out, data_valid_out, data_keep_out, data_len_out,
    output data_last_out, overflow_o
  );

  modport master (
    output input_tdata, input_tvalid, input_tkeep, input_tlast, data_ready_in,
    input  input_tready, data_out, data_valid_out, data_keep_out, data_len_out,
    input  data_last_out, overflow_o
  );

endinterface

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM with one-cycle registered read
// Purpose: packet buffer; one write port, one read port, read data
//          registered and held while i_rd_en is low.
// Ports:
//   i_clk, i_reset          - clock, synchronous active-high reset (read register only)
//   i_wr_en/addr/data       - write port
//   i_rd_en/addr, o_rd_data - read port, data valid the cycle after i_rd_en
`timescale 1ns/1ps
module sdp_ram #(
  parameter int WIDTH      = 72,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data
);

  logic [WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [WIDTH-1:0] r_rd_data;

  // Array itself is not reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Holding the read register when i_rd_en is low gives a free output
  // hold during user-side back-pressure.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/output_writer.sv
// rtl/output_writer.sv - store-and-forward packet writer with length prefix
// Purpose: buffers one whole received packet, then replays it on the user
//          side together with its length in beats. Beats past the buffer
//          depth are accepted and dropped, and a sticky overflow flag is set.
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous active-high reset
//   bus   - output_writer_if.slave: input_t* stream in, data_* user out,
//           overflow_o sticky truncation flag
`timescale 1ns/1ps
module output_writer
  import rio_stream_pkg::*;
#(
  parameter int DATA_WIDTH        = DEFAULT_DATA_WIDTH,
  parameter int DATA_LENGTH_WIDTH = DEFAULT_DATA_LENGTH_WIDTH,
  parameter int RAM_ADDR_WIDTH    = DEFAULT_RAM_ADDR_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  output_writer_if.slave  bus
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int RAM_WIDTH  = DATA_WIDTH + KEEP_WIDTH;
  localparam int CNT_WIDTH  = RAM_ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH = {1'b1, {RAM_ADDR_WIDTH{1'b0}}};

  wr_state_e            r_state;
  logic                 r_tready;
  logic [CNT_WIDTH-1:0] r_beat_cnt;   // doubles as write pointer; saturates at DEPTH
  logic [CNT_WIDTH-1:0] r_rd_ptr;
  logic [CNT_WIDTH-1:0] r_len;
  logic                 r_valid;
  logic                 r_last;
  logic                 r_overflow;

  logic                 w_in_fire;
  logic                 w_wr_en;
  logic                 w_out_fire;
  logic                 w_rd_en;
  logic [CNT_WIDTH-1:0] w_len_next;
  logic [RAM_WIDTH-1:0] w_rd_data;

  assign w_in_fire  = bus.input_tvalid & r_tready & (r_state == FILL);
  // Once the buffer is full the write port stays idle, so nothing wraps.
  assign w_wr_en    = w_in_fire & (r_beat_cnt != DEPTH);
  assign w_out_fire = r_valid & bus.data_ready_in;
  // Fetch the next beat whenever the output register is empty or being
  // consumed this cycle; that keeps one beat per cycle under full ready.
  assign w_rd_en    = (r_state == DRAIN) & (r_rd_ptr != r_len) & (~r_valid | bus.data_ready_in);
  assign w_len_next = (r_beat_cnt == DEPTH) ? DEPTH : r_beat_cnt + 1'b1;

  sdp_ram #(
    .WIDTH      (RAM_WIDTH),
    .ADDR_WIDTH (RAM_ADDR_WIDTH)
  ) u_ram (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_beat_cnt[RAM_ADDR_WIDTH-1:0]),
    .i_wr_data ({bus.input_tkeep, bus.input_tdata}),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr[RAM_ADDR_WIDTH-1:0]),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FILL;
      r_tready   <= 1'b1;
      r_beat_cnt <= '0;
      r_rd_ptr   <= '0;
      r_len      <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_in_fire) begin
            if (r_beat_cnt != DEPTH) begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end else begin
              r_overflow <= 1'b1;
            end
            if (bus.input_tlast) begin
              r_state  <= DRAIN;
              r_tready <= 1'b0;
              r_len    <= w_len_next;
            end
          end
        end
        DRAIN: begin
          if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_valid  <= 1'b1;
            r_last   <= ((r_rd_ptr + 1'b1) == r_len);
          end else if (w_out_fire) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            if (r_last) begin
              r_state    <= FILL;
              r_tready   <= 1'b1;
              r_beat_cnt <= '0;
              r_rd_ptr   <= '0;
            end
          end
        end
      endcase
    end
  end

  // Gating with reset makes tready low throughout reset while the register
  // already holds the FILL value for the first cycle afterwards.
  assign bus.input_tready   = r_tready & ~reset;
  assign bus.data_valid_out = r_valid;
  assign bus.data_last_out  = r_last;
  assign bus.data_len_out   = DATA_LENGTH_WIDTH'(r_len);
  assign bus.data_out       = w_rd_data[DATA_WIDTH-1:0];
  assign bus.data_keep_out  = w_rd_data[RAM_WIDTH-1:DATA_WIDTH];
  assign bus.overflow_o     = r_overflow;

endmodule

// File: tb/tb_output_writer.sv
// tb/tb_output_writer.sv - self-checking bench for output_writer
`timescale 1ns/1ps
module tb_output_writer;

  localparam int DW    = 64;
  localparam int LW    = 20;
  localparam int AW    = 10;
  localparam int KW    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  output_writer_if #(.DATA_WIDTH(DW), .DATA_LENGTH_WIDTH(LW)) bus();

  output_writer #(
    .DATA_WIDTH        (DW),
    .DATA_LENGTH_WIDTH (LW),
    .RAM_ADDR_WIDTH    (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] pkt_data[$];
  logic [KW-1:0] pkt_keep[$];
  logic [DW-1:0] exp_data[$];
  logic [KW-1:0] exp_keep[$];
  int            exp_len;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // kind 0: data 1..n, keep 0xff; kind 1: random data and keep
  task automatic make_pkt(input int n, input int kind);
    pkt_data.delete();
    pkt_keep.delete();
    for (int i = 0; i < n; i++) begin
      if (kind == 0) begin
        pkt_data.push_back(DW'(i + 1));
        pkt_keep.push_back(8'hff);
      end else begin
        pkt_data.push_back({$urandom, $urandom});
        pkt_keep.push_back(8'($urandom));
      end
    end
  endtask

  // Reference: the user sees the first DEPTH beats in order, length capped at DEPTH.
  task automatic build_expect();
    exp_data.delete();
    exp_keep.delete();
    for (int i = 0; i < pkt_data.size() && i < DEPTH; i++) begin
      exp_data.push_back(pkt_data[i]);
      exp_keep.push_back(pkt_keep[i]);
    end
    exp_len = exp_data.size();
  endtask

  task automatic send_pkt();
    for (int i = 0; i < pkt_data.size(); i++) begin
      bus.input_tvalid = 1'b1;
      bus.input_tdata  = pkt_data[i];
      bus.input_tkeep  = pkt_keep[i];
      bus.input_tlast  = (i == pkt_data.size() - 1);
      @(negedge clk);
      check("fill_tready", 64'(bus.input_tready), 64'd1);
      @(posedge clk);
      #1;
    end
    bus.input_tvalid = 1'b0;
    bus.input_tlast  = 1'b0;
  endtask

  // Entered one cycle after the tlast handshake. mode 0: ready=1,
  // 1: ready toggles, 2: random ready. Returns after stop_at beats.
  task automatic recv_pkt(input int mode, input int stop_at);
    int idx = 0;
    int c = 0;
    int first = -1;
    bit prev_stall = 1'b0;
    while (idx < stop_at && c < 5000) begin
      case (mode)
        0:       bus.data_ready_in = 1'b1;
        1:       bus.data_ready_in = (c % 2 == 0);
        default: bus.data_ready_in = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (c == 0) check("drain_tready", 64'(bus.input_tready), 64'd0);
      if (prev_stall) check("valid_held", 64'(bus.data_valid_out), 64'd1);
      if (bus.data_valid_out === 1'b1) begin
        if (first < 0) begin
          first = c;
          check("first_valid_latency", 64'(c), 64'd1);
        end
        check("data", 64'(bus.data_out), 64'(exp_data[idx]));
        check("keep", 64'(bus.data_keep_out), 64'(exp_keep[idx]));
        check("len", 64'(bus.data_len_out), 64'(exp_len));
        check("last", 64'(bus.data_last_out), 64'(idx == exp_len - 1));
        prev_stall = !bus.data_ready_in;
        if (bus.data_ready_in) idx++;
      end else begin
        prev_stall = 1'b0;
      end
      @(posedge clk);
      #1;
      c++;
    end
    check("beats_delivered", 64'(idx), 64'(stop_at));
    bus.data_ready_in = 1'b0;
  endtask

  task automatic after_pkt();
    @(negedge clk);
    check("tready_after_drain", 64'(bus.input_tready), 64'd1);
    check("valid_after_drain", 64'(bus.data_valid_out), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_tready"}, 64'(bus.input_tready), 64'd1);
    check({tag, "_valid"}, 64'(bus.data_valid_out), 64'd0);
    check({tag, "_data"}, 64'(bus.data_out), 64'd0);
    check({tag, "_keep"}, 64'(bus.data_keep_out), 64'd0);
    check({tag, "_len"}, 64'(bus.data_len_out), 64'd0);
    check({tag, "_last"}, 64'(bus.data_last_out), 64'd0);
    check({tag, "_overflow"}, 64'(bus.overflow_o), 64'd0);
  endtask

  initial begin
    bus.input_tvalid  = 1'b0;
    bus.input_tdata   = '0;
    bus.input_tkeep   = '0;
    bus.input_tlast   = 1'b0;
    bus.data_ready_in = 1'b0;
    reset = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_tready", 64'(bus.input_tready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_zero_outputs("post_reset");
    @(posedge clk);
    #1;

    // 268 sequential beats, ready held high
    make_pkt(268, 0);
    build_expect();
    send_pkt();
    recv_pkt(0, exp_len);
    after_pkt();

    // Same packet, ready toggling
    send_pkt();
    recv_pkt(1, exp_len);
    after_pkt();

    // Single-beat packet with partial keep
    pkt_data.delete();
    pkt_keep.delete();
    pkt_data.push_back(64'hA5);
    pkt_keep.push_back(8'h0f);
    build_expect();
    send_pkt();
    recv_pkt(0, exp_len);
    after_pkt();

    // Random packets under random back-pressure
    for (int r = 0; r < 6; r++) begin
      make_pkt(int'($urandom_range(1, 300)), 1);
      build_expect();
      send_pkt();
      recv_pkt(2, exp_len);
      after_pkt();
    end
    check("no_overflow_yet", 64'(bus.overflow_o), 64'd0);

    // Overflow: 1030 beats into a 1024-beat buffer
    make_pkt(1030, 0);
    build_expect();
    send_pkt();
    recv_pkt(0, exp_len);
    check("overflow_set", 64'(bus.overflow_o), 64'd1);
    after_pkt();
    check("overflow_sticky", 64'(bus.overflow_o), 64'd1);

    // Reset in the middle of a drain
    make_pkt(268, 0);
    build_expect();
    send_pkt();
    recv_pkt(0, 100);
    reset = 1'b1;
    @(negedge clk);
    check("mid_reset_tready", 64'(bus.input_tready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_zero_outputs("mid_drain_reset");
    @(posedge clk);
    #1;

    // Short packet after the reset
    make_pkt(4, 1);
    build_expect();
    send_pkt();
    recv_pkt(2, exp_len);
    after_pkt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
